// File: rtl/mux_stage_pkg.sv
// Shared constants and helpers for the registered N-to-1 mux stage.
package mux_stage_pkg;

    localparam int unsigned ERRCNT_W   = 8;
    localparam int unsigned ERRCNT_MAX = 255;

    // Select width for an n-input mux: max(1, clog2(n)).
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_stage_sel.sv
// Purely combinational NUM_IN-to-1 selector with a legal-select flag.
// Out-of-range selects produce an all-zero word.
module mux_stage_sel
    import mux_stage_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 3,
    localparam int unsigned SEL_W = sel_width(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        sel_word_c,
    output logic                    sel_legal_c
);

    // Scan the inputs; only an in-range select matches one of them.
    always_comb begin
        sel_word_c  = '0;
        sel_legal_c = 1'b0;
        for (int k = 0; k < int'(NUM_IN); k++) begin
            if (sel == SEL_W'(k)) begin
                sel_word_c  = in_data[k*WIDTH +: WIDTH];
                sel_legal_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_stage_nto1.sv
// Registered N-to-1 datapath selector stage with stall, flush and select hold.
// Optional illegal-select counter enabled by defining MUX_STAGE_ERRCNT_EN.
module mux_stage_nto1
    import mux_stage_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 3,
    localparam int unsigned SEL_W = sel_width(NUM_IN)
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_hold,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    sel_err
`ifdef MUX_STAGE_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0]     err_count
`endif
);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q,   sel_err_d;
    logic [SEL_W-1:0] last_sel_q,  last_sel_d;
`ifdef MUX_STAGE_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;
`endif

    logic [SEL_W-1:0] eff_sel_c;
    logic [WIDTH-1:0] sel_word_c;
    logic             sel_legal_c;

    // Effective select: reuse the last legal select when holding.
    always_comb begin
        eff_sel_c = sel_hold ? last_sel_q : sel;
    end

    mux_stage_sel #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_sel (
        .in_data     (in_data),
        .sel         (eff_sel_c),
        .sel_word_c  (sel_word_c),
        .sel_legal_c (sel_legal_c)
    );

    // Next-state: flush > stall > capture > idle.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        sel_err_d   = sel_err_q;
        last_sel_d  = last_sel_q;
`ifdef MUX_STAGE_ERRCNT_EN
        err_count_d = err_count_q;
`endif
        if (flush) begin
            out_data_d  = '0;
            out_valid_d = 1'b0;
            sel_err_d   = 1'b0;
        end else if (stall) begin
            // everything holds
        end else if (in_valid) begin
            out_valid_d = 1'b1;
            if (sel_legal_c) begin
                out_data_d = sel_word_c;
                sel_err_d  = 1'b0;
                last_sel_d = eff_sel_c;
            end else begin
                out_data_d = '0;
                sel_err_d  = 1'b1;
`ifdef MUX_STAGE_ERRCNT_EN
                if (err_count_q != ERRCNT_W'(ERRCNT_MAX)) begin
                    err_count_d = err_count_q + ERRCNT_W'(1);
                end
`endif
            end
        end else begin
            out_valid_d = 1'b0;
            sel_err_d   = 1'b0;
        end
    end

    // Stage registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            last_sel_q  <= '0;
`ifdef MUX_STAGE_ERRCNT_EN
            err_count_q <= '0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            last_sel_q  <= last_sel_d;
`ifdef MUX_STAGE_ERRCNT_EN
            err_count_q <= err_count_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;
`ifdef MUX_STAGE_ERRCNT_EN
    assign err_count = err_count_q;
`endif

endmodule

// File: doc/mux_stage_nto1.md
# mux_stage_nto1

Parametrised, registered N-to-1 datapath selector for the pipelined MIPS core. It replaces fixed 3-input combinational forwarding/ALU-source muxes with a single-cycle pipeline stage. It handles width and input count generically and detects illegal selects instead of silently latching. It supports stall and flush from the hazard unit and can reuse the last select (select hold) for multi-cycle operands.

## Interface
- WIDTH, 32, data width per input
- NUM_IN, 3, number of inputs (2..16)
- SEL_W, max(1, clog2(NUM_IN)), select width (derived; not overridden)
- Clk  in  1  rising-edge clock
- Rst_n  in  1  synchronous, active-low reset
- in_data  in  NUM_IN*WIDTH  packed inputs; input k at bits [k*WIDTH +: WIDTH]
- sel  in  SEL_W  binary select
- sel_hold  in  1  use the latched last_sel instead of sel
- in_valid  in  1  stage input qualifier
- stall  in  1  hold all state
- flush  in  1  kill the stage contents
- out_data  out  WIDTH  registered selected word
- out_valid  out  1  out_data is valid
- sel_err  out  1  the registered word came from an illegal select
- err_count  out  8  saturating illegal-select count (only with MUX_STAGE_ERRCNT_EN)

## Operation
- Reset, synchronous, active-low. One clock and one reset only.
- Effective select: eff_sel = sel_hold ? last_sel : sel.
- eff_sel is legal when eff_sel < NUM_IN.
- Per-edge priority: Rst_n low > flush > stall > in_valid capture > idle.
- Rst_n low: out_data=0, out_valid=0, sel_err=0, last_sel=0, err_count=0.
- flush: out_data=0, out_valid=0, sel_err=0. last_sel is kept. flush overrides a simultaneous stall.
- stall (no flush): every register holds, including last_sel and err_count. in_valid is ignored.
- Capture (in_valid=1) with a legal eff_sel:
  - out_data=in_data[eff_sel], out_valid=1, sel_err=0.
  - last_sel is set to eff_sel.
- Capture (in_valid=1) with an illegal eff_sel:
  - out_data=0, out_valid=1, sel_err=1.
  - last_sel is unchanged.
  - err_count increments.
- Idle (in_valid=0): out_valid=0, sel_err=0. out_data and last_sel hold.
- sel_hold with last_sel at its reset value (0) selects input 0. sel_hold is legal from reset.
- When NUM_IN is a power of two, no select is illegal. sel_err stays 0.

## Timing
- Latency is 1 cycle: values present at edge N appear on outputs after edge N.
- Throughput is one word per cycle when stall=0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- A stall of any length preserves out_data, out_valid and sel_err exactly.
- Reset asserted mid-stream takes effect on the next edge regardless of stall or flush.
- err_count saturates at 255 and does not wrap. It clears only on reset, not on flush.

## Configuration
- MUX_STAGE_ERRCNT_EN defined:
  - the err_count port and its 8-bit saturating counter exist.
  - it increments on each illegal-select capture, except while stalled or flushed.
- MUX_STAGE_ERRCNT_EN undefined:
  - err_count port and counter are absent.
  - sel_err behaviour is unchanged.

## Structure
- Package mux_stage_pkg contains:
  - ERRCNT_W=8 and ERRCNT_MAX=255.
  - the sel-width function max(1, clog2(n)), shared with the forwarding unit.
- Sub-module mux_stage_sel: purely combinational NUM_IN-to-1 selector.
  - outputs the selected word and a legal flag.
  - out-of-range selects produce 0.
- mux_stage_nto1 holds all registers, priority logic and the optional counter.

## Test plan
- Reset: drive Rst_n=0 for 2 cycles with in_valid=1, sel=1 -> out_data=0, out_valid=0, sel_err=0, err_count=0.
- Stream, NUM_IN=3: inputs A=0x11111111, B=0x22222222, C=0x33333333; drive sel=0,1,2 on consecutive cycles -> out_data=A,B,C one cycle later, out_valid=1 each cycle.
- Illegal select, NUM_IN=3: sel=3, in_valid=1 -> next cycle out_data=0, out_valid=1, sel_err=1, err_count=1. Then sel=1 -> sel_err=0, err_count stays 1.
- Stall/flush: capture B, then stall=1 for 3 cycles while sel=2 -> out_data stays 0x22222222. Then stall=1 and flush=1 together -> out_valid=0, out_data=0.
- Select hold: capture with sel=2, then sel_hold=1 with sel=0 and C changed to 0x44444444 -> out_data=0x44444444.
- Saturation (macro on): 300 consecutive illegal captures -> err_count=255. WIDTH=8, NUM_IN=4 build: all selects legal, sel_err never asserts.
